// File: rtl/wb_host_driver.sv
`default_nettype none
// ============================================================================
//  Module   : wb_host_driver
//  Purpose  : Wishbone classic single-transfer initiator. Converts a simple
//             valid/ready command into one read or write cycle and returns
//             the read data, or a timeout error when the slave never acks.
//  Options  : define WB_HOST_PROTOCOL_CHECK_EN to compile in bus-protocol
//             immediate assertions (simulation / formal only).
//  Revision : 1.0 - initial release
// ============================================================================
module wb_host_driver #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int ADR_W          = 32,
   parameter int DAT_W          = 32
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   // command side
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_we,
   input  logic [ADR_W-1:0]   cmd_adr,
   input  logic [DAT_W-1:0]   cmd_dat,
   input  logic [DAT_W/8-1:0] cmd_sel,
   // response side
   output logic               rsp_valid,
   output logic [DAT_W-1:0]   rsp_dat,
   output logic               rsp_err,
   // Wishbone master port
   output logic               wbm_cyc_o,
   output logic               wbm_stb_o,
   output logic               wbm_we_o,
   output logic [DAT_W/8-1:0] wbm_sel_o,
   output logic [ADR_W-1:0]   wbm_adr_o,
   output logic [DAT_W-1:0]   wbm_dat_o,
   input  logic               wbm_ack_i,
   input  logic [DAT_W-1:0]   wbm_dat_i
);

   localparam int SEL_W = DAT_W / 8;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

   // Reject configurations the datapath cannot represent.
   if (TIMEOUT_CYCLES < 1 || (DAT_W % 8) != 0) begin : g_param_check
      $error("wb_host_driver: TIMEOUT_CYCLES must be >= 1 and DAT_W a multiple of 8");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             state_q,     state_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [DAT_W-1:0]   rsp_dat_q,   rsp_dat_d;
   logic               rsp_err_q,   rsp_err_d;
   logic               cyc_q,       cyc_d;
   logic               we_q,        we_d;
   logic [SEL_W-1:0]   sel_q,       sel_d;
   logic [ADR_W-1:0]   adr_q,       adr_d;
   logic [DAT_W-1:0]   dat_q,       dat_d;

   // Next-state and registered-output computation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = 1'b0;
      rsp_dat_d   = '0;
      rsp_err_d   = 1'b0;
      cyc_d       = cyc_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;

      case (state_q)
         S_IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               we_d        = cmd_we;
               adr_d       = cmd_adr;
               dat_d       = cmd_dat;
               sel_d       = cmd_sel;
               cyc_d       = 1'b1;
               cnt_d       = '0;
               cmd_ready_d = 1'b0;
               state_d     = S_BUS;
            end
         end
         S_BUS: begin
            cmd_ready_d = 1'b0;
            // Ack has priority over a timeout landing on the same edge.
            if (wbm_ack_i) begin
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = we_q ? '0 : wbm_dat_i;
               state_d     = S_RESP;
            end else if (cnt_q == C_CNT_LAST) begin
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               state_d     = S_RESP;
            end else if (cnt_q != C_CNT_MAX) begin
               cnt_d = cnt_q + C_CNT_ONE;
            end
         end
         S_RESP: begin
            cmd_ready_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            cyc_d       = 1'b0;
            cmd_ready_d = 1'b1;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_dat   = rsp_dat_q;
   assign rsp_err   = rsp_err_q;
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = cyc_q;   // classic cycles: STB always follows CYC
   assign wbm_we_o  = we_q;
   assign wbm_sel_o = sel_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;

`ifdef WB_HOST_PROTOCOL_CHECK_EN
`ifndef SYNTHESIS
   logic               chk_init_q;
   logic               chk_stb_q;
   logic               chk_rsp_q;
   logic               chk_we_q;
   logic [SEL_W-1:0]   chk_sel_q;
   logic [ADR_W-1:0]   chk_adr_q;
   logic [DAT_W-1:0]   chk_dat_q;

   // Bus-protocol checks against the previous cycle's observed outputs.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         assert (wbm_stb_o == wbm_cyc_o)
            else $error("wb_host_driver: stb differs from cyc");
         assert (!(cmd_ready && wbm_cyc_o))
            else $error("wb_host_driver: cmd_ready high during a bus cycle");
         assert (!(wbm_cyc_o && $isunknown(wbm_ack_i)))
            else $error("wb_host_driver: ack unknown during a bus cycle");
         if (chk_init_q) begin
            assert (!(chk_rsp_q && rsp_valid))
               else $error("wb_host_driver: rsp_valid high two cycles");
            if (chk_stb_q && wbm_stb_o) begin
               assert (wbm_we_o == chk_we_q && wbm_sel_o == chk_sel_q &&
                       wbm_adr_o == chk_adr_q && wbm_dat_o == chk_dat_q)
                  else $error("wb_host_driver: bus fields changed while stb high");
            end
         end
      end
      chk_init_q <= !wb_rst_i;
      chk_stb_q  <= wbm_stb_o;
      chk_rsp_q  <= rsp_valid;
      chk_we_q   <= wbm_we_o;
      chk_sel_q  <= wbm_sel_o;
      chk_adr_q  <= wbm_adr_o;
      chk_dat_q  <= wbm_dat_o;
   end
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_host_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_host_driver
//  Purpose  : Directed self-checking bench for wb_host_driver
//             (TIMEOUT_CYCLES = 8, 32-bit address and data).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_host_driver;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we = 1'b0;
   logic [31:0] cmd_adr = '0;
   logic [31:0] cmd_dat = '0;
   logic [3:0]  cmd_sel = '0;
   logic        rsp_valid;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o;
   logic        ack = 1'b0;
   logic [31:0] dat_i = '0;

   int checks   = 0;
   int failures = 0;

   wb_host_driver #(.TIMEOUT_CYCLES(TO), .ADR_W(32), .DAT_W(32)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_adr   (cmd_adr),
      .cmd_dat   (cmd_dat),
      .cmd_sel   (cmd_sel),
      .rsp_valid (rsp_valid),
      .rsp_dat   (rsp_dat),
      .rsp_err   (rsp_err),
      .wbm_cyc_o (cyc),
      .wbm_stb_o (stb),
      .wbm_we_o  (we),
      .wbm_sel_o (sel),
      .wbm_adr_o (adr),
      .wbm_dat_o (dat_o),
      .wbm_ack_i (ack),
      .wbm_dat_i (dat_i)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are then observed 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
      checks++; if ({cyc, stb, we} !== 3'b000) begin failures++; $display("FAIL reset_cyc_stb_we got=%b exp=000", {cyc, stb, we}); end
      checks++; if ({rsp_valid, rsp_err} !== 2'b00) begin failures++; $display("FAIL reset_rsp got=%b exp=00", {rsp_valid, rsp_err}); end
      checks++; if ({rsp_dat, adr, dat_o, sel} !== '0) begin failures++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", rsp_dat, adr, dat_o, sel); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_write();
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0004;
      cmd_dat = 32'hDEAD_BEEF; cmd_sel = 4'hF; dat_i = 32'hFFFF_FFFF;
      step();
      checks++; if ({cyc, stb, cmd_ready} !== 3'b110) begin failures++; $display("FAIL wr_bus cyc_stb_ready got=%b exp=110", {cyc, stb, cmd_ready}); end
      checks++; if ({we, sel, adr, dat_o} !== {1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF})
         begin failures++; $display("FAIL wr_fields got=%b %h %h %h exp=1 f 30000004 deadbeef", we, sel, adr, dat_o); end
      cmd_valid = 1'b0; ack = 1'b1;
      step();
      ack = 1'b0;
      checks++; if ({cyc, stb} !== 2'b00) begin failures++; $display("FAIL wr_cyc_drop got=%b exp=00", {cyc, stb}); end
      checks++; if ({rsp_valid, rsp_err, cmd_ready} !== 3'b100) begin failures++; $display("FAIL wr_rsp valid_err_ready got=%b exp=100", {rsp_valid, rsp_err, cmd_ready}); end
      checks++; if (rsp_dat !== 32'h0) begin failures++; $display("FAIL wr_rsp_dat got=%h exp=00000000", rsp_dat); end
      step();
      checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin failures++; $display("FAIL wr_ready_back valid_ready got=%b exp=01", {rsp_valid, cmd_ready}); end
   endtask

   task automatic test_read_wait();
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0000;
      cmd_dat = 32'h0; cmd_sel = 4'hF; dat_i = 32'h0;
      step();
      // Garbage on the command inputs while busy must be ignored.
      cmd_adr = 32'hBAD0_BAD0; cmd_we = 1'b1; cmd_sel = 4'h1;
      for (int k = 1; k <= 4; k++) begin
         checks++; if ({cyc, stb, we, sel, adr} !== {3'b110, 4'hF, 32'h3000_0000})
            begin failures++; $display("FAIL rd_bus_cycle%0d got=%b%b%b %h %h exp=110 f 30000000", k, cyc, stb, we, sel, adr); end
         if (k == 4) begin ack = 1'b1; dat_i = 32'h0000_00A5; end
         step();
      end
      ack = 1'b0; dat_i = 32'h0; cmd_valid = 1'b0;
      checks++; if ({cyc, rsp_valid, rsp_err} !== 3'b010) begin failures++; $display("FAIL rd_rsp cyc_valid_err got=%b exp=010", {cyc, rsp_valid, rsp_err}); end
      checks++; if (rsp_dat !== 32'h0000_00A5) begin failures++; $display("FAIL rd_rsp_dat got=%h exp=000000a5", rsp_dat); end
      step();
   endtask

   task automatic test_timeout();
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0008; cmd_sel = 4'h3;
      dat_i = 32'h5555_AAAA;
      step();
      cmd_valid = 1'b0;
      for (int k = 1; k <= TO; k++) begin
         checks++; if (cyc !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL to_bus_cycle%0d cyc_valid got=%b%b exp=10", k, cyc, rsp_valid); end
         step();
      end
      checks++; if ({cyc, rsp_valid, rsp_err} !== 3'b011) begin failures++; $display("FAIL to_rsp cyc_valid_err got=%b exp=011", {cyc, rsp_valid, rsp_err}); end
      checks++; if (rsp_dat !== 32'h0) begin failures++; $display("FAIL to_rsp_dat got=%h exp=00000000", rsp_dat); end
      step();
      checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin failures++; $display("FAIL to_ready_back ready_valid got=%b exp=10", {cmd_ready, rsp_valid}); end
   endtask

   task automatic test_ack_last();
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_000C; cmd_sel = 4'hF;
      dat_i = 32'h0;
      step();
      cmd_valid = 1'b0;
      for (int k = 1; k <= TO; k++) begin
         checks++; if (cyc !== 1'b1) begin failures++; $display("FAIL al_bus_cycle%0d cyc got=%b exp=1", k, cyc); end
         if (k == TO) begin ack = 1'b1; dat_i = 32'h1234_5678; end
         step();
      end
      ack = 1'b0; dat_i = 32'h0;
      checks++; if ({cyc, rsp_valid, rsp_err} !== 3'b010) begin failures++; $display("FAIL al_rsp cyc_valid_err got=%b exp=010", {cyc, rsp_valid, rsp_err}); end
      checks++; if (rsp_dat !== 32'h1234_5678) begin failures++; $display("FAIL al_rsp_dat got=%h exp=12345678", rsp_dat); end
      step();
   endtask

   task automatic test_reset_mid();
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0010;
      cmd_dat = 32'hCAFE_F00D; cmd_sel = 4'hF;
      step();
      cmd_valid = 1'b0;
      checks++; if (cyc !== 1'b1) begin failures++; $display("FAIL rm_bus1 cyc got=%b exp=1", cyc); end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if ({cyc, stb, cmd_ready, rsp_valid} !== 4'b0010) begin failures++; $display("FAIL rm_after_reset cyc_stb_ready_valid got=%b exp=0010", {cyc, stb, cmd_ready, rsp_valid}); end
      ack = 1'b1; dat_i = 32'h7777_7777;
      for (int k = 0; k < 2; k++) begin
         step();
         checks++; if ({cyc, rsp_valid, cmd_ready} !== 3'b001) begin failures++; $display("FAIL rm_stray_ack%0d cyc_valid_ready got=%b exp=001", k, {cyc, rsp_valid, cmd_ready}); end
      end
      ack = 1'b0; dat_i = 32'h0;
   endtask

   task automatic test_back_to_back();
      int rise[2];
      int rsp[2];
      int nrise = 0;
      int nrsp  = 0;
      logic prev_cyc = 1'b0;
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0020;
      cmd_dat = 32'h1111_1111; cmd_sel = 4'hF;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (cyc && !prev_cyc && nrise < 2) begin
            rise[nrise] = c;
            if (nrise == 0) begin
               checks++; if (adr !== 32'h3000_0020) begin failures++; $display("FAIL b2b_adr1 got=%h exp=30000020", adr); end
               cmd_we = 1'b0; cmd_adr = 32'h3000_0024;
            end else begin
               checks++; if ({we, adr} !== {1'b0, 32'h3000_0024}) begin failures++; $display("FAIL b2b_adr2 got=%b %h exp=0 30000024", we, adr); end
               cmd_valid = 1'b0;
            end
            nrise++;
         end
         if (rsp_valid && nrsp < 2) begin rsp[nrsp] = c; nrsp++; end
         ack = cyc;            // zero-wait-state slave
         dat_i = 32'h0000_0042;
         prev_cyc = cyc;
      end
      ack = 1'b0; cmd_valid = 1'b0;
      checks++; if (nrise !== 2 || nrsp !== 2) begin failures++; $display("FAIL b2b_counts rises=%0d rsps=%0d exp=2/2", nrise, nrsp); end
      else begin
         checks++; if (rise[0] !== 1) begin failures++; $display("FAIL b2b_first_rise got=%0d exp=1", rise[0]); end
         checks++; if (rise[1] - rise[0] !== 3) begin failures++; $display("FAIL b2b_cyc_spacing got=%0d exp=3", rise[1] - rise[0]); end
         checks++; if (rsp[1] - rsp[0] !== 3) begin failures++; $display("FAIL b2b_rsp_spacing got=%0d exp=3", rsp[1] - rsp[0]); end
         checks++; if (rsp[0] !== 2) begin failures++; $display("FAIL b2b_first_rsp got=%0d exp=2", rsp[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_timeout();
      test_ack_last();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_host_driver.md
Name: wb_host_driver

Overview:
- Wishbone classic single-transfer initiator, the host end of the user-project Wishbone slave port (wbs_* signals).
- Turns a simple command handshake into one Wishbone read or write cycle and returns the read data or a timeout error.
- Used as the bus host in block-level benches and in the formal harness around user-project wrappers.
- A wrapper that is not active never acks, so the driver must terminate hung cycles itself.

Parameters:
- TIMEOUT_CYCLES, 64, bus cycles without ack before the driver aborts the transfer; must be >= 1.
- ADR_W, 32, address width.
- DAT_W, 32, data width; must be a multiple of 8. SEL_W = DAT_W/8.

Ports:
- wb_clk_i  input  1  clock; all logic is on the rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  driver can accept a command this cycle.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_adr  input  ADR_W  byte address.
- cmd_dat  input  DAT_W  write data.
- cmd_sel  input  SEL_W  byte enables.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_dat  output  DAT_W  read data; 0 for writes and on error.
- rsp_err  output  1  transfer ended by timeout; qualified by rsp_valid.
- wbm_cyc_o  output  1  Wishbone CYC.
- wbm_stb_o  output  1  Wishbone STB.
- wbm_we_o  output  1  Wishbone WE.
- wbm_sel_o  output  SEL_W  Wishbone SEL.
- wbm_adr_o  output  ADR_W  Wishbone ADR.
- wbm_dat_o  output  DAT_W  Wishbone DAT (write data).
- wbm_ack_i  input  1  Wishbone ACK from the slave.
- wbm_dat_i  input  DAT_W  Wishbone DAT (read data from the slave).

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of wb_clk_i.
  - After the reset edge all outputs are 0 except cmd_ready, which is 1.
  - State goes to IDLE; the timeout counter clears.
  - Reset asserted mid-transfer drops cyc/stb at that edge. No response is issued for the aborted transfer.
- FSM, all outputs registered:
  - IDLE: cmd_ready = 1. On cmd_valid && cmd_ready, latch we/adr/dat/sel into the wbm_* registers, set cyc = stb = 1, clear the counter, go to BUS.
  - BUS: cyc = stb = 1; the wbm_* fields hold stable; cmd_ready = 0.
    - wbm_ack_i = 1 at an edge: cyc = stb = 0; rsp_valid = 1, rsp_err = 0; rsp_dat = wbm_dat_i for a read, 0 for a write; go to RESP.
    - No ack and counter == TIMEOUT_CYCLES-1: cyc = stb = 0; rsp_valid = 1, rsp_err = 1, rsp_dat = 0; go to RESP.
    - Otherwise increment the counter.
  - RESP: rsp_valid is high for this one cycle only; cmd_ready = 0; next state IDLE.
- Latency:
  - Command accepted at edge E0: cyc/stb are high in the cycle after E0.
  - Ack sampled at edge Ek: rsp_valid is high in the cycle after Ek and cyc/stb are already low.
  - cmd_ready returns one cycle after rsp_valid.
  - With a zero-wait-state slave: accept, 1 bus cycle, 1 response cycle, then ready. Back-to-back throughput is 1 command per 3 cycles.
- The timeout counter has width clog2(TIMEOUT_CYCLES+1), saturates, and never wraps.
- Ack and timeout at the same edge: ack wins, rsp_err = 0.
- wbm_ack_i is ignored outside BUS; a stray ack causes no response.
- wbm_dat_i is ignored on writes.
- wbm_we_o, wbm_adr_o, wbm_sel_o and wbm_dat_o keep their last values when cyc = 0. Those values are don't-care but stable.
- cmd_* inputs are ignored whenever cmd_ready = 0.
- Classic cycles only: no CTI/BTE, no pipelined STB, stb == cyc at all times.

Optional Feature:
- Macro: WB_HOST_PROTOCOL_CHECK_EN.
- Defined: the block includes immediate assertions (active only under FORMAL or simulation), each flagging if violated:
  - stb == cyc;
  - wbm_adr_o/wbm_we_o/wbm_sel_o/wbm_dat_o change while stb is high;
  - rsp_valid is high for 2 consecutive cycles;
  - cmd_ready and cyc are high together;
  - wbm_ack_i is X/Z while cyc is high.
- Not defined: no checker logic or assertions are compiled; functional RTL is identical.

Test Plan:
- Write, zero-wait slave: cmd_we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF, slave acks in the first bus cycle -> cyc/stb high exactly 1 cycle with those fields; rsp_valid=1, rsp_err=0, rsp_dat=0 the next cycle; cmd_ready=1 one cycle later.
- Read, 3 wait states: cmd_we=0, adr=0x3000_0000, slave acks on the 4th bus cycle with dat_i=0x0000_00A5 -> cyc high 4 cycles, fields stable; rsp_dat=0x0000_00A5, rsp_err=0.
- Timeout, TIMEOUT_CYCLES=8, slave never acks -> cyc high exactly 8 cycles; rsp_valid=1, rsp_err=1, rsp_dat=0; the next command is accepted normally.
- Ack on the last timeout cycle, TIMEOUT_CYCLES=8, ack in the 8th bus cycle with dat_i=0x1234_5678 -> rsp_err=0, rsp_dat=0x1234_5678.
- Reset mid-transfer: wb_rst_i=1 on the 2nd bus cycle -> cyc/stb=0 and cmd_ready=1 after that edge; no rsp_valid; a stray ack afterwards produces no response.
- Back-to-back: cmd_valid held high with 2 commands, zero-wait slave -> second cyc rises exactly 3 cycles after the first; rsp_valid pulses 3 cycles apart.
